// File: rtl/tri_raster_v4_pkg.sv
// Shared definitions for the tri_raster_v4 triangle rasteriser:
// state encoding, accumulator width derivation and bounding-box helpers.
package tri_raster_pkg;

  localparam int COORD_W_DEF = 16;
  localparam int MM_W        = 32;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_SETUP = 3'd1;
  localparam logic [2:0] ST_INIT  = 3'd2;
  localparam logic [2:0] ST_SCAN  = 3'd3;
  localparam logic [2:0] ST_DONE  = 3'd4;

  typedef enum logic [2:0] {
    IDLE  = ST_IDLE,
    SETUP = ST_SETUP,
    INIT  = ST_INIT,
    SCAN  = ST_SCAN,
    DONE  = ST_DONE
  } state_t;

  // Two product terms of span 2^w each, plus sign and headroom for the difference.
  function automatic int acc_width(input int coord_w);
    return 32'sd2 * coord_w + 32'sd3;
  endfunction

  function automatic logic [MM_W-1:0] min3(input logic [MM_W-1:0] a,
                                           input logic [MM_W-1:0] b,
                                           input logic [MM_W-1:0] c);
    logic [MM_W-1:0] m;
    if (a < b) m = a;
    else       m = b;
    if (c < m) m = c;
    return m;
  endfunction

  function automatic logic [MM_W-1:0] max3(input logic [MM_W-1:0] a,
                                           input logic [MM_W-1:0] b,
                                           input logic [MM_W-1:0] c);
    logic [MM_W-1:0] m;
    if (a > b) m = a;
    else       m = b;
    if (c > m) m = c;
    return m;
  endfunction

endpackage

// File: rtl/tri_raster_v4_if.sv
// Command and pixel-stream bundle of the rasteriser; slave is the rasteriser side.
interface tri_raster_v4_if
  import tri_raster_pkg::*;
#(
  parameter int COORD_W = COORD_W_DEF
);
  logic                   start;
  logic [2*COORD_W-1:0]   v0;
  logic [2*COORD_W-1:0]   v1;
  logic [2*COORD_W-1:0]   v2;
  logic [COORD_W-1:0]     x;
  logic [COORD_W-1:0]     y;
  logic                   valid;
  logic                   ready;
  logic                   busy;
  logic                   done;

  modport master (output start, v0, v1, v2, ready,
                  input  x, y, valid, busy, done);
  modport slave  (input  start, v0, v1, v2, ready,
                  output x, y, valid, busy, done);
endinterface

// File: rtl/tri_raster_v4_edge_eval.sv
// Combinational edge function E(a,b,p) = (bx-ax)*(py-ay) - (by-ay)*(px-ax),
// evaluated signed on zero-extended coordinates.
module tri_edge_eval
  import tri_raster_pkg::*;
#(
  parameter int COORD_W = COORD_W_DEF,
  parameter int ACC_W   = acc_width(COORD_W)
) (
  input  logic [COORD_W-1:0]       ax,
  input  logic [COORD_W-1:0]       ay,
  input  logic [COORD_W-1:0]       bx,
  input  logic [COORD_W-1:0]       by,
  input  logic [COORD_W-1:0]       px,
  input  logic [COORD_W-1:0]       py,
  output logic signed [ACC_W-1:0]  e
);
  typedef logic signed [ACC_W-1:0] acc_t;

  function automatic acc_t ext(input logic [COORD_W-1:0] v);
    return acc_t'({{(ACC_W-COORD_W){1'b0}}, v});
  endfunction

  acc_t dx_ab_s, dy_ab_s, dx_ap_s, dy_ap_s;

  assign dx_ab_s = ext(bx) - ext(ax);
  assign dy_ab_s = ext(by) - ext(ay);
  assign dx_ap_s = ext(px) - ext(ax);
  assign dy_ap_s = ext(py) - ext(ay);
  assign e       = (dx_ab_s * dy_ap_s) - (dy_ab_s * dx_ap_s);
endmodule

// File: rtl/tri_raster_v4.sv
// Single-triangle rasteriser: clipped bounding-box scan, one candidate per cycle,
// covered pixels streamed row-major on a valid/ready port that holds under stall.
module tri_raster_v4
  import tri_raster_pkg::*;
#(
  parameter int COORD_W  = COORD_W_DEF,
  parameter int VERTEX_W = 2 * COORD_W,
  parameter int SCREEN_W = 320,
  parameter int SCREEN_H = 240,
  parameter int ACC_W    = acc_width(COORD_W)
) (
  input  logic           clk,
  input  logic           resetn,
  tri_raster_v4_if.slave bus
);
  typedef logic signed [ACC_W-1:0] acc_t;

  localparam logic [COORD_W-1:0] X_LIM = COORD_W'(SCREEN_W - 1);
  localparam logic [COORD_W-1:0] Y_LIM = COORD_W'(SCREEN_H - 1);
  localparam logic [COORD_W-1:0] ONE   = COORD_W'(1);

  function automatic acc_t ext(input logic [COORD_W-1:0] v);
    return acc_t'({{(ACC_W-COORD_W){1'b0}}, v});
  endfunction

  state_t             state_r, state_nxt;
  logic [COORD_W-1:0] ax_r, ay_r, bx_r, by_r, cx_r, cy_r;
  logic [COORD_W-1:0] xmin_r, xmax_r, ymin_r, ymax_r, px_r, py_r, x_r, y_r;
  logic               valid_r, busy_r, done_r, neg_r, last_r;
  acc_t               row_e_r [3];
  acc_t               cur_e_r [3];
  acc_t               stx_r   [3];
  acc_t               sty_r   [3];

  acc_t               area_s;
  acc_t               org_e_s [3];
  acc_t               stx_s   [3];
  acc_t               sty_s   [3];
  logic [MM_W-1:0]    mn_x_s, mx_x_s, mn_y_s, mx_y_s;
  logic [COORD_W-1:0] xmax_s, ymax_s;
  logic               degen_s, cov_s, advance_s, at_xend_s, at_last_s;

  tri_edge_eval #(.COORD_W(COORD_W), .ACC_W(ACC_W)) u_e0 (
    .ax(bx_r), .ay(by_r), .bx(cx_r), .by(cy_r), .px(xmin_r), .py(ymin_r), .e(org_e_s[0]));
  tri_edge_eval #(.COORD_W(COORD_W), .ACC_W(ACC_W)) u_e1 (
    .ax(cx_r), .ay(cy_r), .bx(ax_r), .by(ay_r), .px(xmin_r), .py(ymin_r), .e(org_e_s[1]));
  tri_edge_eval #(.COORD_W(COORD_W), .ACC_W(ACC_W)) u_e2 (
    .ax(ax_r), .ay(ay_r), .bx(bx_r), .by(by_r), .px(xmin_r), .py(ymin_r), .e(org_e_s[2]));
  tri_edge_eval #(.COORD_W(COORD_W), .ACC_W(ACC_W)) u_area (
    .ax(ax_r), .ay(ay_r), .bx(bx_r), .by(by_r), .px(cx_r), .py(cy_r), .e(area_s));

  // Bounding box with screen clamp, and rejection of empty or off-screen triangles.
  always_comb begin
    mn_x_s = min3(MM_W'(ax_r), MM_W'(bx_r), MM_W'(cx_r));
    mx_x_s = max3(MM_W'(ax_r), MM_W'(bx_r), MM_W'(cx_r));
    mn_y_s = min3(MM_W'(ay_r), MM_W'(by_r), MM_W'(cy_r));
    mx_y_s = max3(MM_W'(ay_r), MM_W'(by_r), MM_W'(cy_r));
    if (mx_x_s > MM_W'(X_LIM)) xmax_s = X_LIM;
    else                       xmax_s = mx_x_s[COORD_W-1:0];
    if (mx_y_s > MM_W'(Y_LIM)) ymax_s = Y_LIM;
    else                       ymax_s = mx_y_s[COORD_W-1:0];
    degen_s = (area_s == '0) || (mn_x_s > MM_W'(X_LIM)) || (mn_y_s > MM_W'(Y_LIM));
  end

  // Per-edge increments: d/dx = -(by-ay), d/dy = bx-ax; negated for clockwise input.
  always_comb begin
    stx_s[0] = ext(by_r) - ext(cy_r);
    sty_s[0] = ext(cx_r) - ext(bx_r);
    stx_s[1] = ext(cy_r) - ext(ay_r);
    sty_s[1] = ext(ax_r) - ext(cx_r);
    stx_s[2] = ext(ay_r) - ext(by_r);
    sty_s[2] = ext(bx_r) - ext(ax_r);
    if (neg_r) begin
      for (int i = 0; i < 3; i++) begin
        stx_s[i] = -stx_s[i];
        sty_s[i] = -sty_s[i];
      end
    end else begin
      stx_s = stx_s;
      sty_s = sty_s;
    end
  end

  assign cov_s     = !(cur_e_r[0][ACC_W-1] || cur_e_r[1][ACC_W-1] || cur_e_r[2][ACC_W-1]);
  assign advance_s = !valid_r || bus.ready;
  assign at_xend_s = (px_r == xmax_r);
  assign at_last_s = at_xend_s && (py_r == ymax_r);

  // Next-state logic.
  always_comb begin
    state_nxt = state_r;
    case (state_r)
      IDLE:    if (bus.start) state_nxt = SETUP; else state_nxt = IDLE;
      SETUP:   if (degen_s)   state_nxt = DONE;  else state_nxt = INIT;
      INIT:    state_nxt = SCAN;
      SCAN: begin
        if (last_r) begin
          if (advance_s) state_nxt = DONE; else state_nxt = SCAN;
        end else if (advance_s && at_last_s && !cov_s) begin
          state_nxt = DONE;
        end else begin
          state_nxt = SCAN;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!resetn) state_r <= IDLE;
    else         state_r <= state_nxt;
  end

  // Vertex capture, setup, edge accumulators, scan position and output slot.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      {ax_r, ay_r, bx_r, by_r, cx_r, cy_r} <= '0;
      {xmin_r, xmax_r, ymin_r, ymax_r, px_r, py_r, x_r, y_r} <= '0;
      {valid_r, busy_r, done_r, neg_r, last_r} <= 5'b0_0000;
      for (int i = 0; i < 3; i++) begin
        row_e_r[i] <= '0;
        cur_e_r[i] <= '0;
        stx_r[i]   <= '0;
        sty_r[i]   <= '0;
      end
    end else begin
      busy_r <= (state_nxt != IDLE);
      done_r <= (state_nxt == DONE);
      case (state_r)
        IDLE: begin
          if (bus.start) begin
            ax_r <= bus.v0[VERTEX_W-1:COORD_W];
            ay_r <= bus.v0[COORD_W-1:0];
            bx_r <= bus.v1[VERTEX_W-1:COORD_W];
            by_r <= bus.v1[COORD_W-1:0];
            cx_r <= bus.v2[VERTEX_W-1:COORD_W];
            cy_r <= bus.v2[COORD_W-1:0];
          end
        end
        SETUP: begin
          xmin_r <= mn_x_s[COORD_W-1:0];
          ymin_r <= mn_y_s[COORD_W-1:0];
          xmax_r <= xmax_s;
          ymax_r <= ymax_s;
          neg_r  <= area_s[ACC_W-1];
        end
        INIT: begin
          for (int i = 0; i < 3; i++) begin
            row_e_r[i] <= neg_r ? -org_e_s[i] : org_e_s[i];
            cur_e_r[i] <= neg_r ? -org_e_s[i] : org_e_s[i];
            stx_r[i]   <= stx_s[i];
            sty_r[i]   <= sty_s[i];
          end
          px_r   <= xmin_r;
          py_r   <= ymin_r;
          last_r <= 1'b0;
        end
        SCAN: begin
          if (advance_s && last_r) begin
            valid_r <= 1'b0;
          end else if (advance_s) begin
            valid_r <= cov_s;
            if (cov_s) begin
              x_r <= px_r;
              y_r <= py_r;
            end
            if (at_last_s) begin
              last_r <= 1'b1;
            end else if (at_xend_s) begin
              px_r <= xmin_r;
              py_r <= py_r + ONE;
              for (int i = 0; i < 3; i++) begin
                row_e_r[i] <= row_e_r[i] + sty_r[i];
                cur_e_r[i] <= row_e_r[i] + sty_r[i];
              end
            end else begin
              px_r <= px_r + ONE;
              for (int i = 0; i < 3; i++) cur_e_r[i] <= cur_e_r[i] + stx_r[i];
            end
          end
        end
        DONE:    valid_r <= 1'b0;
        default: valid_r <= 1'b0;
      endcase
    end
  end

  assign bus.x     = x_r;
  assign bus.y     = y_r;
  assign bus.valid = valid_r;
  assign bus.busy  = busy_r;
  assign bus.done  = done_r;
endmodule

// File: tb/tb_tri_raster_v4.sv
// Scoreboard bench for tri_raster_v4: a reference rasteriser fills the expected
// queue, a negedge monitor drives ready, pops and compares every transfer.
module tb_tri_raster_v4;
  logic clk = 1'b0;
  logic resetn;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  tri_raster_v4_if #(.COORD_W(16)) bus  ();
  tri_raster_v4_if #(.COORD_W(16)) bus8 ();

  tri_raster_v4 #(.COORD_W(16), .SCREEN_W(320), .SCREEN_H(240)) dut (
    .clk(clk), .resetn(resetn), .bus(bus));
  tri_raster_v4 #(.COORD_W(16), .SCREEN_W(8), .SCREEN_H(8)) dut8 (
    .clk(clk), .resetn(resetn), .bus(bus8));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  logic [31:0] exp_q [$];
  logic [31:0] obs8_q [$];
  logic [31:0] mdl_q [$];
  int          mdl_cand, mdl_first_idx;
  bit          mdl_last_cov, mdl_degen;
  int          xfer_cnt = 0, stall_cnt = 0, done_cnt = 0, done_cyc = 0, done8_cnt = 0;
  int          first_valid_cyc = -1;
  bit          ready_rand = 1'b0;
  logic [15:0] lfsr = 16'hACE1;

  task automatic chk(input string name, input longint act, input longint req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  function automatic longint ef(longint ax, longint ay, longint bx, longint by,
                                longint px, longint py);
    return (bx - ax) * (py - ay) - (by - ay) * (px - ax);
  endfunction

  function automatic longint mn3(longint a, longint b, longint c);
    longint m = (a < b) ? a : b;
    return (c < m) ? c : m;
  endfunction

  function automatic longint mx3(longint a, longint b, longint c);
    longint m = (a > b) ? a : b;
    return (c > m) ? c : m;
  endfunction

  // Reference: every pixel of the clipped box tested against all three edges.
  task automatic model(input int sw, input int sh, input longint ax, input longint ay,
                       input longint bx, input longint by, input longint cx, input longint cy);
    longint area, s, x0, x1, y0, y1;
    bit cov;
    mdl_q.delete();
    mdl_cand = 0; mdl_last_cov = 1'b0; mdl_first_idx = -1;
    area = ef(ax, ay, bx, by, cx, cy);
    s  = (area < 0) ? -1 : 1;
    x0 = mn3(ax, bx, cx); x1 = mx3(ax, bx, cx);
    y0 = mn3(ay, by, cy); y1 = mx3(ay, by, cy);
    if (x1 > sw - 1) x1 = sw - 1;
    if (y1 > sh - 1) y1 = sh - 1;
    mdl_degen = (area == 0) || (x0 > sw - 1) || (y0 > sh - 1);
    if (!mdl_degen) begin
      for (longint py = y0; py <= y1; py++) begin
        for (longint px = x0; px <= x1; px++) begin
          cov = (s * ef(bx, by, cx, cy, px, py) >= 0) && (s * ef(cx, cy, ax, ay, px, py) >= 0)
             && (s * ef(ax, ay, bx, by, px, py) >= 0);
          if (cov && mdl_first_idx < 0) mdl_first_idx = mdl_cand;
          if (cov) mdl_q.push_back({px[15:0], py[15:0]});
          if (px == x1 && py == y1) mdl_last_cov = cov;
          mdl_cand++;
        end
      end
    end
  endtask

  // Monitor for the full-screen instance: drives ready, checks hold and order.
  initial begin
    logic        rdy, hold_pending;
    logic [31:0] got, e, hold_pix;
    hold_pending = 1'b0;
    hold_pix     = 32'd0;
    bus.ready    = 1'b1;
    forever begin
      @(negedge clk);
      if (ready_rand) begin
        lfsr = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
        rdy  = lfsr[0];
      end else begin
        rdy = 1'b1;
      end
      bus.ready = rdy;
      got = {bus.x, bus.y};
      if (resetn) begin
        if (hold_pending) begin
          checks++;
          if (!bus.valid || got != hold_pix) begin
            errors++;
            $display("FAIL hold_stable: got valid=%0b (%0d,%0d), required valid=1 (%0d,%0d)",
                     bus.valid, bus.x, bus.y, hold_pix[31:16], hold_pix[15:0]);
          end
        end
        hold_pending = bus.valid && !rdy;
        hold_pix     = got;
        if (bus.valid && !rdy) stall_cnt++;
        if (bus.valid && first_valid_cyc < 0) first_valid_cyc = cyc;
        if (bus.valid && rdy) begin
          xfer_cnt++;
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL extra_pixel: got (%0d,%0d), required none", bus.x, bus.y);
          end else begin
            e = exp_q.pop_front();
            if (got != e) begin
              errors++;
              $display("FAIL pixel: got (%0d,%0d), required (%0d,%0d)",
                       bus.x, bus.y, e[31:16], e[15:0]);
            end
          end
        end
        if (bus.done) begin
          done_cnt++;
          done_cyc = cyc;
        end
      end else begin
        hold_pending = 1'b0;
      end
    end
  end

  // Collector for the 8x8 instance.
  initial begin
    bus8.ready = 1'b1;
    forever begin
      @(negedge clk);
      if (resetn) begin
        if (bus8.valid) obs8_q.push_back({bus8.x, bus8.y});
        if (bus8.done) done8_cnt++;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic run_tri(input string name, input int ax, input int ay, input int bx,
                         input int by, input int cx, input int cy, input bit rnd);
    int t0, d0, s0, n, lim;
    model(320, 240, ax, ay, bx, by, cx, cy);
    exp_q = mdl_q;
    ready_rand = rnd;
    first_valid_cyc = -1;
    d0 = done_cnt;
    s0 = stall_cnt;
    bus.v0 = {ax[15:0], ay[15:0]};
    bus.v1 = {bx[15:0], by[15:0]};
    bus.v2 = {cx[15:0], cy[15:0]};
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    t0 = cyc;
    chk({name, " busy_after_start"}, bus.busy, 1);
    lim = 4 * mdl_cand + 50;
    n = 0;
    while (done_cnt == d0 && n < lim) begin
      tick();
      n++;
    end
    chk({name, " done_seen"}, done_cnt - d0, 1);
    if (done_cnt != d0) begin
      chk({name, " done_cycle"}, done_cyc - t0,
          mdl_degen ? 1 : 2 + mdl_cand + (stall_cnt - s0) + int'(mdl_last_cov));
      chk({name, " pixels_missing"}, exp_q.size(), 0);
      chk({name, " first_valid"}, (mdl_first_idx >= 0) ? first_valid_cyc - t0 : first_valid_cyc,
          (mdl_first_idx >= 0) ? 3 + mdl_first_idx : -1);
      chk({name, " idle_after_done"}, {bus.done, bus.busy, bus.valid}, 0);
    end
    exp_q.delete();
    ready_rand = 1'b0;
  endtask

  initial begin
    int n, x0, d0, bxo, byo;
    int vx [3];
    int vy [3];
    resetn = 1'b0;
    bus.start = 1'b0; bus.v0 = 32'd0; bus.v1 = 32'd0; bus.v2 = 32'd0;
    bus8.start = 1'b0; bus8.v0 = 32'd0; bus8.v1 = 32'd0; bus8.v2 = 32'd0;
    repeat (3) tick();
    chk("reset_outputs", {bus.x, bus.y, bus.valid, bus.busy, bus.done}, 0);
    chk("reset_outputs8", {bus8.x, bus8.y, bus8.valid, bus8.busy, bus8.done}, 0);
    resetn = 1'b1;
    tick();

    run_tri("tri15", 0, 0, 4, 0, 0, 4, 1'b0);
    run_tri("tri15_cw", 0, 0, 0, 4, 4, 0, 1'b0);
    run_tri("collinear", 0, 0, 2, 2, 4, 4, 1'b0);
    run_tri("offscreen_x", 400, 10, 410, 10, 400, 20, 1'b0);
    run_tri("clip_right", 310, 100, 330, 100, 310, 120, 1'b0);
    run_tri("clip_bottom", 10, 230, 20, 250, 0, 250, 1'b0);
    run_tri("tri15_lfsr", 0, 0, 4, 0, 0, 4, 1'b1);

    model(8, 8, 4, 0, 12, 0, 4, 8);
    obs8_q.delete();
    d0 = done8_cnt;
    bus8.v0 = {16'd4, 16'd0};
    bus8.v1 = {16'd12, 16'd0};
    bus8.v2 = {16'd4, 16'd8};
    bus8.start = 1'b1;
    tick();
    bus8.start = 1'b0;
    n = 0;
    while (done8_cnt == d0 && n < 200) begin
      tick();
      n++;
    end
    chk("clip8 done_seen", done8_cnt - d0, 1);
    chk("clip8 pixel_count", obs8_q.size(), mdl_q.size());
    for (int i = 0; i < obs8_q.size() && i < mdl_q.size(); i++)
      chk("clip8 pixel", obs8_q[i], mdl_q[i]);

    model(320, 240, 0, 0, 4, 0, 0, 4);
    exp_q = mdl_q;
    x0 = xfer_cnt;
    d0 = done_cnt;
    bus.v0 = {16'd0, 16'd0};
    bus.v1 = {16'd4, 16'd0};
    bus.v2 = {16'd0, 16'd4};
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    n = 0;
    while (xfer_cnt - x0 < 5 && n < 100) begin
      tick();
      n++;
    end
    chk("rst_mid transfers", xfer_cnt - x0, 5);
    resetn = 1'b0;
    tick();
    resetn = 1'b1;
    chk("rst_mid outputs", {bus.valid, bus.busy, bus.done}, 0);
    exp_q.delete();
    repeat (30) tick();
    chk("rst_mid no_done", done_cnt - d0, 0);
    run_tri("tri15_after_rst", 0, 0, 4, 0, 0, 4, 1'b0);

    for (int k = 0; k < 12; k++) begin
      bxo = ($urandom_range(0, 3) == 0) ? 305 : int'($urandom_range(0, 200));
      byo = ($urandom_range(0, 3) == 0) ? 225 : int'($urandom_range(0, 150));
      for (int j = 0; j < 3; j++) begin
        vx[j] = bxo + int'($urandom_range(0, 24));
        vy[j] = byo + int'($urandom_range(0, 24));
      end
      run_tri("random", vx[0], vy[0], vx[1], vy[1], vx[2], vy[2], k[0]);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
